// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and slave state indices, used by ahb_slave_if and ahb_master_if.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned S_IDLE_IDX   = 0;
  localparam int unsigned S_ACCESS_IDX = 1;
  localparam int unsigned S_ERR1_IDX   = 2;
  localparam int unsigned S_ERR2_IDX   = 3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'(1 << S_IDLE_IDX),
    ST_ACCESS = 4'(1 << S_ACCESS_IDX),
    ST_ERR1   = 4'(1 << S_ERR1_IDX),
    ST_ERR2   = 4'(1 << S_ERR2_IDX)
  } slv_state_t;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_if_if.sv
// AHB-Lite bus signals seen by one slave: master drives address/data phase, slave returns response.
interface ahb_slave_if_if #(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32
);
  logic                      ahb_sel_in;
  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in;
  logic [1:0]                ahb_trans_in;
  logic [2:0]                ahb_burst_in;
  logic [2:0]                ahb_size_in;
  logic                      ahb_write_in;
  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in;
  logic                      ahb_ready_in;
  logic                      ahb_readyout_out;
  logic                      ahb_resp_out;
  logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out;

  modport slave (
    input  ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_burst_in, ahb_size_in,
           ahb_write_in, ahb_wdata_in, ahb_ready_in,
    output ahb_readyout_out, ahb_resp_out, ahb_rdata_out
  );

  modport master (
    output ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_burst_in, ahb_size_in,
           ahb_write_in, ahb_wdata_in, ahb_ready_in,
    input  ahb_readyout_out, ahb_resp_out, ahb_rdata_out
  );
endinterface

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobe from transfer size and low address bits; lanes beyond the bus width are dropped.
module ahb_strb_gen #(
  parameter int unsigned AHB_DATA_WIDTH = 32
) (
  input  logic [2:0]                  size_in,
  input  logic [2:0]                  addr_in,
  output logic [AHB_DATA_WIDTH/8-1:0] strb_out
);
  localparam int unsigned LANES = AHB_DATA_WIDTH / 8;

  // Lane i is enabled when it falls inside [offset, offset + bytes).
  always_comb begin
    int unsigned off;
    int unsigned bytes;
    off      = 32'(addr_in) & (LANES - 1);
    bytes    = 32'd1 << size_in;
    strb_out = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      strb_out[i] = (i >= off) && (i < off + bytes);
    end
  end
endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end: turns each accepted transfer into one request/ack beat on the backend port.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH   = 32,
  parameter int unsigned AHB_DATA_WIDTH   = 32,
  parameter int unsigned AHB_WAIT_TIMEOUT = 6
) (
  input  logic                        ahb_clk_in,
  input  logic                        ahb_rst_in,
  ahb_slave_if_if.slave               ahb,
  output logic                        other_valid_out,
  output logic [AHB_ADDR_WIDTH-1:0]   other_addr_out,
  output logic                        other_write_out,
  output logic [2:0]                  other_size_out,
  output logic [2:0]                  other_burst_out,
  output logic [AHB_DATA_WIDTH/8-1:0] other_strb_out,
  output logic [AHB_DATA_WIDTH-1:0]   other_wdata_out,
  input  logic                        other_ready_in,
  input  logic                        other_error_in,
  input  logic [AHB_DATA_WIDTH-1:0]   other_rdata_in
);
  localparam int unsigned WCNT_W = $clog2(AHB_WAIT_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(AHB_WAIT_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(AHB_WAIT_TIMEOUT);

  slv_state_t                state_q, state_d, accept_state;
  logic [WCNT_W-1:0]         wait_cnt_q;
  logic                      accept, size_bad, addr_bad, load;
  logic                      readyout, resp;
  logic [AHB_DATA_WIDTH-1:0] rdata;

  // Classify the address phase on the bus: nothing, a legal transfer, or one that must error.
  always_comb begin
    int unsigned align_mask;
    accept       = ahb.ahb_sel_in & ahb.ahb_ready_in & trans_active(ahb.ahb_trans_in);
    size_bad     = (32'd8 << ahb.ahb_size_in) > AHB_DATA_WIDTH;
    align_mask   = (32'd1 << ahb.ahb_size_in) - 32'd1;
    addr_bad     = (ahb.ahb_addr_in & AHB_ADDR_WIDTH'(align_mask)) != '0;
    accept_state = !accept ? ST_IDLE : ((size_bad | addr_bad) ? ST_ERR1 : ST_ACCESS);
  end

  // State register.
  always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
    if (ahb_rst_in) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state; load marks the cycles where a new address phase may be taken.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = accept_state;
        load    = accept;
      end
      ST_ACCESS: begin
        // A backend ack in the timeout cycle still completes the transfer normally.
        if (other_ready_in) begin
          if (other_error_in) begin
            state_d = ST_ERR2;
          end else begin
            state_d = accept_state;
            load    = accept;
          end
        end else if (wait_cnt_q == WCNT_LAST) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: begin
        state_d = accept_state;
        load    = accept;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus response and backend request, combinational from state and backend ack.
  always_comb begin
    readyout        = 1'b1;
    resp            = HRESP_OKAY;
    rdata           = '0;
    other_valid_out = 1'b0;
    unique case (state_q)
      ST_ACCESS: begin
        other_valid_out = 1'b1;
        readyout        = other_ready_in & ~other_error_in;
        resp            = (other_ready_in & other_error_in) ? HRESP_ERROR : HRESP_OKAY;
        if (other_ready_in & ~other_write_out) rdata = other_rdata_in;
      end
      ST_ERR1: begin
        readyout = 1'b0;
        resp     = HRESP_ERROR;
      end
      ST_ERR2: resp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign ahb.ahb_readyout_out = readyout;
  assign ahb.ahb_resp_out     = resp;
  assign ahb.ahb_rdata_out    = rdata;
  assign other_wdata_out      = other_valid_out ? ahb.ahb_wdata_in : '0;

  // Capture the accepted address phase and count backend wait cycles (saturating).
  always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
    if (ahb_rst_in) begin
      other_addr_out  <= '0;
      other_write_out <= 1'b0;
      other_size_out  <= '0;
      other_burst_out <= '0;
      wait_cnt_q      <= '0;
    end else if (load) begin
      other_addr_out  <= ahb.ahb_addr_in;
      other_write_out <= ahb.ahb_write_in;
      other_size_out  <= ahb.ahb_size_in;
      other_burst_out <= ahb.ahb_burst_in;
      wait_cnt_q      <= '0;
    end else if (state_q == ST_ACCESS && !other_ready_in && wait_cnt_q != WCNT_MAX) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  ahb_strb_gen #(.AHB_DATA_WIDTH(AHB_DATA_WIDTH)) u_strb (
    .size_in  (other_size_out),
    .addr_in  (other_addr_out[2:0]),
    .strb_out (other_strb_out)
  );
endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if with a transfer-level reference model checked every cycle.
module tb_ahb_slave_if;
  import ahb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_slave_if_if #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW)) bus ();

  logic          other_valid, other_write, other_ready, other_error;
  logic [AW-1:0] other_addr;
  logic [2:0]    other_size, other_burst;
  logic [3:0]    other_strb;
  logic [DW-1:0] other_wdata, other_rdata;

  // Single slave on the bus: the muxed HREADY is this slave's HREADYOUT.
  assign bus.ahb_ready_in = bus.ahb_readyout_out;

  ahb_slave_if #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW), .AHB_WAIT_TIMEOUT(TO)) dut (
    .ahb_clk_in      (clk),
    .ahb_rst_in      (rst),
    .ahb             (bus),
    .other_valid_out (other_valid),
    .other_addr_out  (other_addr),
    .other_write_out (other_write),
    .other_size_out  (other_size),
    .other_burst_out (other_burst),
    .other_strb_out  (other_strb),
    .other_wdata_out (other_wdata),
    .other_ready_in  (other_ready),
    .other_error_in  (other_error),
    .other_rdata_in  (other_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Backend: acks after be_delay wait cycles, or never; optional error with the ack.
  int            be_delay = 0;
  bit            be_never = 0;
  bit            be_err   = 0;
  logic [DW-1:0] be_rdata = '0;

  initial begin
    int  be_cnt;
    bit  prev_valid;
    be_cnt      = 0;
    prev_valid  = 0;
    other_ready = 1'b0;
    other_error = 1'b0;
    other_rdata = '0;
    forever begin
      @(posedge clk);
      if (prev_valid && !other_ready) be_cnt++;
      else                            be_cnt = 0;
      #1;
      prev_valid  = other_valid;
      other_ready = other_valid && !be_never && (be_cnt >= be_delay);
      other_error = other_ready && be_err;
      other_rdata = other_ready ? be_rdata : '0;
    end
  end

  // Reference model: which transfer is in its data phase and how many error cycles remain.
  bit            m_access;
  int            m_err_left;
  int            m_wait;
  logic [AW-1:0] m_addr;
  logic          m_write;
  logic [2:0]    m_size, m_burst;

  // Activity counters and last-completion captures, used by the directed literal checks.
  int            n_low, n_valid, n_err;
  logic [DW-1:0] cap_rdata, cap_wdata;
  logic [3:0]    cap_strb;

  // Compare DUT against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic          e_rdy, e_rsp;
    logic [DW-1:0] e_rd, e_wd;
    logic [63:0]   strb_w;
    bit            done;
    int unsigned   bytes;
    if (rst) begin
      m_access = 0; m_err_left = 0; m_wait = 0;
      m_addr = '0; m_write = 0; m_size = '0; m_burst = '0;
      chk("rst_readyout", bus.ahb_readyout_out, 1);
      chk("rst_resp",     bus.ahb_resp_out, 0);
      chk("rst_rdata",    bus.ahb_rdata_out, 0);
      chk("rst_valid",    other_valid, 0);
      chk("rst_addr",     other_addr, 0);
      chk("rst_write",    other_write, 0);
      chk("rst_size",     other_size, 0);
      chk("rst_burst",    other_burst, 0);
    end else begin
      e_rdy = 1'b1; e_rsp = 1'b0; e_rd = '0;
      if (m_err_left == 2) begin
        e_rdy = 1'b0; e_rsp = 1'b1;
      end else if (m_err_left == 1) begin
        e_rsp = 1'b1;
      end else if (m_access) begin
        if (other_ready) begin
          e_rdy = !other_error;
          e_rsp = other_error;
          if (!m_write) e_rd = other_rdata;
        end else begin
          e_rdy = 1'b0;
        end
      end
      e_wd = m_access ? bus.ahb_wdata_in : '0;
      chk("readyout", bus.ahb_readyout_out, e_rdy);
      chk("resp",     bus.ahb_resp_out, e_rsp);
      chk("rdata",    bus.ahb_rdata_out, e_rd);
      chk("valid",    other_valid, m_access);
      chk("wdata",    other_wdata, e_wd);
      chk("addr",     other_addr, m_addr);
      chk("write",    other_write, m_write);
      chk("size",     other_size, m_size);
      chk("burst",    other_burst, m_burst);
      if (m_access) begin
        bytes  = 32'd1 << m_size;
        strb_w = ((64'd1 << bytes) - 64'd1) << (m_addr % 4);
        chk("strb", other_strb, strb_w[3:0]);
      end

      if (!bus.ahb_readyout_out) n_low++;
      if (other_valid) n_valid++;
      if (bus.ahb_resp_out) n_err++;
      if (other_valid && bus.ahb_readyout_out) begin
        cap_rdata = bus.ahb_rdata_out;
        cap_wdata = other_wdata;
        cap_strb  = other_strb;
      end

      done = (!m_access && m_err_left == 0) || m_err_left == 1 ||
             (m_access && other_ready && !other_error);
      if (done) begin
        m_access = 0; m_err_left = 0;
        if (bus.ahb_sel_in && bus.ahb_trans_in >= 2) begin
          m_addr = bus.ahb_addr_in; m_write = bus.ahb_write_in;
          m_size = bus.ahb_size_in; m_burst = bus.ahb_burst_in;
          bytes  = 32'd1 << bus.ahb_size_in;
          if (bytes * 8 > DW || (bus.ahb_addr_in % bytes) != 0) begin
            m_err_left = 2;
          end else begin
            m_access = 1; m_wait = 0;
          end
        end
      end else if (m_err_left == 2) begin
        m_err_left = 1;
      end else if (m_access && other_ready) begin
        m_access = 0; m_err_left = 1;
      end else if (m_access) begin
        m_wait++;
        if (m_wait == TO) begin
          m_access = 0; m_err_left = 2;
        end
      end
    end
  end

  // Present one address phase and hold it until HREADY is high at a rising edge.
  task automatic beat(input logic [1:0] trans, input logic [AW-1:0] addr, input logic [2:0] size,
                      input logic wr, input logic [2:0] burst, input logic [DW-1:0] data);
    int   n;
    logic r;
    n = 0;
    bus.ahb_sel_in   = 1'b1;
    bus.ahb_trans_in = trans;
    bus.ahb_addr_in  = addr;
    bus.ahb_size_in  = size;
    bus.ahb_write_in = wr;
    bus.ahb_burst_in = burst;
    forever begin
      @(negedge clk);
      r = bus.ahb_readyout_out;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 40) begin
        bound_fail("beat_accept");
        break;
      end
    end
    bus.ahb_wdata_in = (trans[1] && wr) ? data : '0;
  endtask

  // Drive IDLE and wait until the last data phase (and any error response) is over.
  task automatic finish();
    int n;
    n = 0;
    bus.ahb_sel_in   = 1'b0;
    bus.ahb_trans_in = HTRANS_IDLE;
    forever begin
      @(negedge clk);
      if (bus.ahb_readyout_out && !other_valid && !bus.ahb_resp_out) break;
      n++;
      if (n > 40) begin
        bound_fail("finish_idle");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.ahb_wdata_in = '0;
  endtask

  int s_low, s_valid, s_err;
  task automatic snap();
    s_low = n_low; s_valid = n_valid; s_err = n_err;
  endtask

  task automatic chk_counts(input string tag, input int lows, input int valids, input int errs);
    chk({tag, "_low_cycles"},   n_low - s_low, lows);
    chk({tag, "_valid_cycles"}, n_valid - s_valid, valids);
    chk({tag, "_resp_cycles"},  n_err - s_err, errs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    bus.ahb_sel_in = 1'b0; bus.ahb_trans_in = HTRANS_IDLE; bus.ahb_addr_in = '0;
    bus.ahb_size_in = '0; bus.ahb_write_in = 1'b0; bus.ahb_burst_in = '0; bus.ahb_wdata_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single write, zero-wait backend.
    snap();
    beat(HTRANS_NONSEQ, 32'h10, 3'd2, 1'b1, HBURST_SINGLE, 32'hA5A5_A5A5);
    finish();
    chk("wr_strb", cap_strb, 4'hF);
    chk("wr_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk_counts("wr", 0, 1, 0);

    // Read with three backend wait cycles.
    be_delay = 3; be_rdata = 32'h1234_5678;
    snap();
    beat(HTRANS_NONSEQ, 32'h04, 3'd2, 1'b0, HBURST_SINGLE, '0);
    finish();
    chk("rd_rdata", cap_rdata, 32'h1234_5678);
    chk_counts("rd", 3, 4, 0);
    be_delay = 0;

    // Unaligned address, then oversize transfer: each gives ERR1/ERR2 with no request.
    snap();
    beat(HTRANS_NONSEQ, 32'h02, 3'd2, 1'b1, HBURST_SINGLE, 32'h1);
    finish();
    chk_counts("unaligned", 1, 0, 2);
    snap();
    beat(HTRANS_NONSEQ, 32'h08, 3'd3, 1'b0, HBURST_SINGLE, '0);
    finish();
    chk_counts("oversize", 1, 0, 2);

    // Backend never acks: six wait cycles, then the two-cycle error.
    be_never = 1;
    snap();
    beat(HTRANS_NONSEQ, 32'h50, 3'd2, 1'b0, HBURST_SINGLE, '0);
    finish();
    chk_counts("timeout", 7, 6, 2);
    be_never = 0;

    // INCR4 write burst with a BUSY in the middle, zero-wait backend.
    snap();
    beat(HTRANS_NONSEQ, 32'h20, 3'd2, 1'b1, HBURST_INCR4, 32'h1111_0000);
    beat(HTRANS_SEQ,    32'h24, 3'd2, 1'b1, HBURST_INCR4, 32'h2222_0001);
    beat(HTRANS_BUSY,   32'h28, 3'd2, 1'b1, HBURST_INCR4, '0);
    beat(HTRANS_SEQ,    32'h28, 3'd2, 1'b1, HBURST_INCR4, 32'h3333_0002);
    beat(HTRANS_SEQ,    32'h2C, 3'd2, 1'b1, HBURST_INCR4, 32'h4444_0003);
    finish();
    chk("burst_last_wdata", cap_wdata, 32'h4444_0003);
    chk_counts("burst", 0, 4, 0);

    // Pipelined sub-word writes with an unaligned halfword in the middle, then a read.
    be_rdata = 32'hCAFE_F00D;
    snap();
    beat(HTRANS_NONSEQ, 32'h13, 3'd0, 1'b1, HBURST_SINGLE, 32'h7700_0000);
    beat(HTRANS_NONSEQ, 32'h15, 3'd1, 1'b1, HBURST_SINGLE, 32'h0000_BEEF);
    beat(HTRANS_NONSEQ, 32'h16, 3'd1, 1'b1, HBURST_SINGLE, 32'hBEEF_0000);
    beat(HTRANS_NONSEQ, 32'h18, 3'd2, 1'b0, HBURST_SINGLE, '0);
    finish();
    chk("mixed_rdata", cap_rdata, 32'hCAFE_F00D);
    chk_counts("mixed", 1, 3, 2);

    // Backend error with ack.
    be_err = 1;
    snap();
    beat(HTRANS_NONSEQ, 32'h30, 3'd2, 1'b1, HBURST_SINGLE, 32'h5A5A_5A5A);
    finish();
    chk_counts("be_err", 1, 1, 2);
    be_err = 0;

    // Reset asserted while a request is outstanding.
    be_never = 1;
    beat(HTRANS_NONSEQ, 32'h40, 3'd2, 1'b0, HBURST_SINGLE, '0);
    bus.ahb_sel_in = 1'b0; bus.ahb_trans_in = HTRANS_IDLE;
    #2;
    chk("pre_rst_valid", other_valid, 1);
    chk("pre_rst_readyout", bus.ahb_readyout_out, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", other_valid, 0);
    chk("mid_rst_readyout", bus.ahb_readyout_out, 1);
    chk("mid_rst_resp", bus.ahb_resp_out, 0);
    chk("mid_rst_addr", other_addr, 0);
    be_never = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Recovery after reset.
    snap();
    beat(HTRANS_NONSEQ, 32'h44, 3'd2, 1'b1, HBURST_SINGLE, 32'h0BAD_F00D);
    finish();
    chk("post_rst_wdata", cap_wdata, 32'h0BAD_F00D);
    chk_counts("post_rst", 0, 1, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
